// File: rtl/wishbone_sram_bridge.sv
// Wishbone device-side bridge to a single-port synchronous-read SRAM macro.
// Out-of-range accesses answer with error instead of ack and leave the SRAM untouched.
module wishbone_sram_bridge #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_data_i,
  input  logic [23:0]           wb_adr_i,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic                  wb_error_o,
  output logic [31:0]           wb_data_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0,
  output logic [1:0]            probe_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    ACK       = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   in_range;

  // Shifting the whole address keeps the ignored byte-offset bits referenced.
  assign in_range = ((wb_adr_i >> (ADDR_WIDTH + 2)) == 24'd0);
  assign accept   = (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!in_range)    state_nxt = ERROR;
          else if (wb_we_i) state_nxt = ACK;
          else              state_nxt = READ_WAIT;
        end
      end
      READ_WAIT: state_nxt = wb_cyc_i ? ACK : IDLE;
      ACK:       state_nxt = IDLE;
      ERROR:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = 4'h0;
    sram_addr0  = wb_adr_i[ADDR_WIDTH+1:2];
    sram_din0   = wb_data_i;
    if (accept && in_range) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~wb_we_i;
      sram_wmask0 = wb_sel_i;
    end
    wb_stall_o  = (state != IDLE);
    wb_ack_o    = (state == ACK) && wb_cyc_i;
    wb_error_o  = (state == ERROR) && wb_cyc_i;
    probe_state = state;
  end

  // SRAM output is valid during READ_WAIT; an aborted read leaves the old value.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                            wb_data_o <= 32'h0;
    else if (state == READ_WAIT && wb_cyc_i) wb_data_o <= sram_dout0;
  end

endmodule

// File: tb/tb_wishbone_sram_bridge.sv
// Directed bench for wishbone_sram_bridge with a behavioural synchronous-read SRAM.
module tb_wishbone_sram_bridge;
  localparam int ADDR_WIDTH = 9;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cyc, stb, we;
  logic [3:0]            sel;
  logic [31:0]           wdata;
  logic [23:0]           adr;
  logic                  ack, stall, err;
  logic [31:0]           rdata;
  logic                  csb0, web0;
  logic [3:0]            wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [31:0]           din0, dout0;
  logic [1:0]            pstate;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wishbone_sram_bridge #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_data_i(wdata), .wb_adr_i(adr), .wb_ack_o(ack),
    .wb_stall_o(stall), .wb_error_o(err), .wb_data_o(rdata), .sram_csb0(csb0),
    .sram_web0(web0), .sram_wmask0(wmask0), .sram_addr0(addr0), .sram_din0(din0),
    .sram_dout0(dout0), .probe_state(pstate)
  );

  // OpenRAM-style macro: masked write or registered read when csb0 is low.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdata = 32'h0; adr = 24'h0;
  endtask

  task automatic req(input logic w, input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdata = d; sel = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req(1'b1, 24'h000010, 32'h11111111, 4'hF);
    tick;
    #1;
    check1("reset_csb0", csb0, 1'b1);
    check1("reset_web0", web0, 1'b1);
    check32("reset_wmask0", {28'h0, wmask0}, 32'h0);
    check1("reset_ack", ack, 1'b0);
    check1("reset_stall", stall, 1'b0);
    check1("reset_err", err, 1'b0);
    check32("reset_data", rdata, 32'h0);
    check32("reset_state", {30'h0, pstate}, 32'h0);
    rst = 1'b0;
    idle_bus();
    tick;
  endtask

  task automatic test_write;
    req(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
    #1;
    check1("wr_csb0", csb0, 1'b0);
    check1("wr_web0", web0, 1'b0);
    check32("wr_addr0", {23'h0, addr0}, 32'd4);
    check32("wr_wmask0", {28'h0, wmask0}, 32'hF);
    check1("wr_stall_T", stall, 1'b0);
    tick;
    stb = 1'b0;
    #1;
    check1("wr_ack_T1", ack, 1'b1);
    check1("wr_stall_T1", stall, 1'b1);
    check1("wr_csb0_T1", csb0, 1'b1);
    tick;
    #1;
    check1("wr_ack_T2", ack, 1'b0);
    check1("wr_stall_T2", stall, 1'b0);
    idle_bus();
  endtask

  task automatic do_read(input string name, input logic [23:0] a, input logic [31:0] exp);
    req(1'b0, a, 32'h0, 4'hF);
    #1;
    check1({name, "_csb0"}, csb0, 1'b0);
    check1({name, "_web0"}, web0, 1'b1);
    tick;
    stb = 1'b0;
    #1;
    check1({name, "_stall_T1"}, stall, 1'b1);
    check1({name, "_ack_T1"}, ack, 1'b0);
    tick;
    #1;
    check1({name, "_ack_T2"}, ack, 1'b1);
    check1({name, "_stall_T2"}, stall, 1'b1);
    check32({name, "_data"}, rdata, exp);
    tick;
    idle_bus();
  endtask

  task automatic test_read;
    do_read("rd", 24'h000010, 32'hDEADBEEF);
  endtask

  task automatic test_byte_write;
    req(1'b1, 24'h000010, 32'h0000AA00, 4'h2);
    #1;
    check32("bw_wmask0", {28'h0, wmask0}, 32'h2);
    tick;
    stb = 1'b0;
    #1;
    check1("bw_ack", ack, 1'b1);
    tick;
    idle_bus();
    do_read("bw_rd", 24'h000010, 32'hDEADAAEF);
  endtask

  task automatic test_sel_zero;
    req(1'b1, 24'h000013, 32'h55555555, 4'h0);
    #1;
    check1("sel0_csb0", csb0, 1'b0);
    check32("sel0_wmask0", {28'h0, wmask0}, 32'h0);
    tick;
    stb = 1'b0;
    #1;
    check1("sel0_ack", ack, 1'b1);
    check32("sel0_data_hold", rdata, 32'hDEADAAEF);
    tick;
    idle_bus();
    do_read("sel0_rd", 24'h000010, 32'hDEADAAEF);
  endtask

  task automatic test_error;
    req(1'b0, 24'h000800, 32'h0, 4'hF);
    #1;
    check1("err_csb0", csb0, 1'b1);
    tick;
    stb = 1'b0;
    #1;
    check1("err_error", err, 1'b1);
    check1("err_ack", ack, 1'b0);
    check1("err_stall", stall, 1'b1);
    check32("err_state", {30'h0, pstate}, 32'd3);
    tick;
    req(1'b1, 24'h000014, 32'h12345678, 4'hF);
    #1;
    check1("err_next_csb0", csb0, 1'b0);
    check1("err_next_stall", stall, 1'b0);
    check1("err_next_error", err, 1'b0);
    check32("err_next_addr0", {23'h0, addr0}, 32'd5);
    tick;
    stb = 1'b0;
    #1;
    check1("err_next_ack", ack, 1'b1);
    check32("err_data_hold", rdata, 32'hDEADAAEF);
    tick;
    idle_bus();
  endtask

  task automatic test_abort;
    req(1'b0, 24'h000014, 32'h0, 4'hF);
    tick;
    cyc = 1'b0; stb = 1'b0;
    #1;
    check32("ab_state_T1", {30'h0, pstate}, 32'd1);
    tick;
    #1;
    check1("ab_ack_T2", ack, 1'b0);
    check32("ab_data", rdata, 32'hDEADAAEF);
    check32("ab_state_T2", {30'h0, pstate}, 32'd0);
    idle_bus();
    do_read("ab_rd", 24'h000014, 32'h12345678);
  endtask

  task automatic test_reset_mid;
    req(1'b0, 24'h000010, 32'h0, 4'hF);
    tick;
    stb = 1'b0;
    rst = 1'b1;
    #1;
    check32("rm_state_rw", {30'h0, pstate}, 32'd1);
    tick;
    rst = 1'b0;
    idle_bus();
    #1;
    check32("rm_state", {30'h0, pstate}, 32'd0);
    check32("rm_data", rdata, 32'h0);
    check1("rm_ack", ack, 1'b0);
    check1("rm_err", err, 1'b0);
    check1("rm_stall", stall, 1'b0);
    check1("rm_csb0", csb0, 1'b1);
    check1("rm_web0", web0, 1'b1);
    check32("rm_wmask0", {28'h0, wmask0}, 32'h0);
    req(1'b1, 24'h000020, 32'hCAFEF00D, 4'hF);
    tick;
    stb = 1'b0;
    #1;
    check1("rm_wr_ack", ack, 1'b1);
    tick;
    idle_bus();
    do_read("rm_rd", 24'h000020, 32'hCAFEF00D);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'h0;
    dout0 = 32'h0;
    rst = 1'b1;
    idle_bus();
    test_reset();
    test_write();
    test_read();
    test_byte_write();
    test_sel_zero();
    test_error();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_sram_bridge.md
Name: wishbone_sram_bridge

Overview:
- Wishbone device-side bridge that sits directly downstream of the multi-controller device mux.
- Consumes the mux's device_* bus: cyc, stb, we, sel, 32-bit data, 24-bit address, and returns ack, stall, error and read data.
- Drives one port of a single-port, synchronous-read SRAM macro (OpenRAM-style, active-low strobes, per-byte write mask).
- Checks address range and flags out-of-range accesses with error instead of ack.

Parameters:
- ADDR_WIDTH, 9, SRAM word-address width. Depth is 2^ADDR_WIDTH 32-bit words, so byte span is 2^(ADDR_WIDTH+2).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle active
- wb_stb_i  in  1  request strobe
- wb_we_i  in  1  1 = write, 0 = read
- wb_sel_i  in  4  byte selects
- wb_data_i  in  32  write data
- wb_adr_i  in  24  byte address
- wb_ack_o  out  1  transfer acknowledge
- wb_stall_o  out  1  request not accepted this cycle
- wb_error_o  out  1  out-of-range access
- wb_data_o  out  32  read data (registered)
- sram_csb0  out  1  SRAM chip select, active low
- sram_web0  out  1  SRAM write enable, active low
- sram_wmask0  out  4  SRAM byte write mask
- sram_addr0  out  ADDR_WIDTH  SRAM word address
- sram_din0  out  32  SRAM write data
- sram_dout0  in  32  SRAM read data; valid the cycle after the cycle csb0 was low
- probe_state  out  2  current FSM state, for logic probes

Behaviour:
- States and encodings: IDLE=0, READ_WAIT=1, ACK=2, ERROR=3. probe_state = state.
- wb_stall_o = (state != IDLE). A request is accepted when state==IDLE && wb_cyc_i && wb_stb_i.
- Range check:
  - in range iff wb_adr_i[23:ADDR_WIDTH+2] == 0
  - word address = wb_adr_i[ADDR_WIDTH+1:2]; wb_adr_i[1:0] ignored
- SRAM drive (combinational):
  - In the accept cycle and in range: sram_csb0=0, sram_web0=~wb_we_i, sram_addr0 = word address, sram_din0=wb_data_i, sram_wmask0=wb_sel_i.
  - All other cycles: csb0=1, web0=1, wmask0=0. addr0 and din0 follow the inputs (don't-care).
- Transitions:
  - IDLE, accept, out of range -> ERROR. SRAM is not touched.
  - IDLE, accept, write -> ACK.
  - IDLE, accept, read -> READ_WAIT.
  - READ_WAIT: capture sram_dout0 into wb_data_o, then -> ACK. If wb_cyc_i==0 in this cycle, go to IDLE with no capture (abort).
  - ACK -> IDLE, unconditionally.
  - ERROR -> IDLE, unconditionally.
- Outputs:
  - wb_ack_o = (state==ACK) && wb_cyc_i.
  - wb_error_o = (state==ERROR) && wb_cyc_i.
  - ack and error are single-cycle and mutually exclusive.
- Latency, accept edge to ack/error: write 1 cycle, read 2 cycles, error 1 cycle.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- wb_data_o holds the last read value and is not updated by writes or errors.
- A write with sel=0 still performs the SRAM cycle (mask 0, so no bytes change) and acks.
- Controller drops cyc after a write is accepted: the SRAM write has already completed; ack is suppressed and the FSM returns to IDLE.
- Reset, including mid-operation: state=IDLE, wb_data_o=0, ack/error/stall=0, csb0=1, web0=1, wmask0=0. The reset cycle accepts no request.

Test Plan:
- Write adr 0x000010, data 0xDEADBEEF, sel 0xF -> accept cycle drives csb0=0, web0=0, addr0=4, wmask0=0xF; ack=1 on the next cycle; stall=1 for exactly 1 cycle.
- Read adr 0x000010 after the write above -> csb0=0, web0=1 at T; ack=1 at T+2 with data_o=0xDEADBEEF; stall high at T+1 and T+2.
- Byte write adr 0x000010, sel 0x2, data 0x0000AA00, then read -> data_o=0xDEADAAEF.
- Out-of-range adr 0x000800 (ADDR_WIDTH=9) -> csb0 stays 1; error=1 at T+1, ack=0; next request accepted at T+2.
- Read with cyc dropped at T+1 -> no ack at T+2, data_o unchanged, probe_state back to 0 at T+2.
- wb_rst_i asserted while in READ_WAIT -> next cycle all outputs at reset values, probe_state=0; a following write acks with 1-cycle latency.
